bitrev_engine: RTL
==================

BITREV_ENGINE -- requirements
Module: bitrev_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits (>=2).
REQ-002 SHALL have parameter N_WORDS, default 4, buffer depth in words (power of 2, >=2); IDX_W = log2(N_WORDS).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port din_i  input  DATA_W  write data word.
REQ-006 SHALL have port write_i  input  1  write strobe, level; one word is accepted per rising edge.
REQ-007 SHALL have port start_flag_i  input  1  start processing, sampled per cycle.
REQ-008 SHALL have port mode_i  input  2  bit0 = reverse bits within each word; bit1 = reorder words by bit-reversed index.
REQ-009 SHALL have port read_i  input  1  read strobe, level; one word is consumed per rising edge.
REQ-010 SHALL have port dout_o  output  DATA_W  current result word.
REQ-011 SHALL have port done_flag_o  output  1  results available.
REQ-012 SHALL have port busy_o  output  1  high in PROC.

Function
REQ-013 SHALL implement FSM states LOAD, PROC, DONE.
REQ-014 SHALL detect rising edges of write_i and read_i against a registered previous value; the previous value SHALL update every cycle in every state, so a level held across a state change produces no edge.
REQ-015 In LOAD, each write_i rising edge SHALL store din_i into in_buf[wr_ptr] and increment wr_ptr; when wr_ptr == N_WORDS (full), further write edges SHALL be ignored.
REQ-016 In LOAD, start_flag_i=1 SHALL latch mode_i, clear the processing index, and enter PROC on that edge, whatever wr_ptr is; never-written entries SHALL read as 0.
REQ-017 If a write edge and start_flag_i occur in the same LOAD cycle, the word SHALL be stored and included in processing.
REQ-018 In PROC, one word per cycle SHALL be processed: out_buf[k] = f(in_buf[j]), where j = bit-reverse of k over IDX_W bits if mode bit1 is set, else j = k, and f reverses the DATA_W bits of the word if mode bit0 is set, else passes it through.
REQ-019 After index N_WORDS-1 is processed, the FSM SHALL enter DONE; done_flag_o SHALL rise exactly N_WORDS edges after the edge that sampled start.
REQ-020 In DONE, dout_o SHALL equal out_buf[rd_ptr] combinationally from registers; each read_i rising edge SHALL increment rd_ptr.
REQ-021 The read edge that consumes word N_WORDS-1 SHALL return the FSM to LOAD and clear wr_ptr, rd_ptr and in_buf; done_flag_o SHALL fall on that edge.
REQ-022 Outside DONE, dout_o SHALL be 0.
REQ-023 start_flag_i in PROC or DONE, write edges in PROC or DONE, and read edges in LOAD or PROC SHALL be ignored without side effects.
REQ-024 mode_i changes after the start-sampling edge SHALL NOT affect the current run.

Reset
REQ-025 rst_ni low SHALL immediately force LOAD, clear all pointers, buffers, latched mode and edge-detect registers, and drive dout_o=0, done_flag_o=0, busy_o=0, including mid-PROC or mid-DONE.
REQ-026 After rst_ni deasserts, a write_i already high SHALL NOT count as an edge until it falls and rises again.

Verification
REQ-027 The bench SHALL cover: N=4, W=32, mode=01; write 0x00000001, 0x80000000, 0x0000FFFF, 0x12345678; start -> 4 reads return 0x80000000, 0x00000001, 0xFFFF0000, 0x1E6A2C48.
REQ-028 The bench SHALL cover: mode=10; write A=0x11, B=0x22, C=0x33, D=0x44; start -> reads return 0x11, 0x33, 0x22, 0x44; busy_o high for exactly 4 cycles; done_flag_o rises 4 edges after start.
REQ-029 The bench SHALL cover: mode=11, same data -> reads return 0x88000000, 0xCC000000, 0x44000000, 0x22000000.
REQ-030 The bench SHALL cover: 6 write edges with 0x1..0x6, mode=00, start -> reads return 0x1..0x4; write_i held high across states produces no extra capture.
REQ-031 The bench SHALL cover: 2 writes, start on the same cycle as the 2nd write, mode=00 -> reads return w0, w1, 0, 0; after the 4th read, state is LOAD and done_flag_o=0.
REQ-032 The bench SHALL cover: rst_ni pulsed low mid-PROC and again after 2 of 4 reads in DONE -> all outputs read 0 immediately; a fresh 4-word run then completes correctly.

Source files
------------

// File: rtl/bitrev_engine.sv
// Buffered bit-reversal engine: loads N_WORDS words, then reorders them by
// bit-reversed index and/or reverses bits within each word, then streams results out.
module bitrev_engine #(
  parameter int DATA_W  = 32,
  parameter int N_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] din_i,
  input  logic              write_i,
  input  logic              start_flag_i,
  input  logic [1:0]        mode_i,
  input  logic              read_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              done_flag_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {LOAD, PROC, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W:0]      wr_ptr_q;
  logic [IDX_W-1:0]    rd_ptr_q;
  logic [IDX_W-1:0]    k_q;
  logic [1:0]          mode_q;
  logic                wr_prev_q, rd_prev_q;
  logic                wr_arm_q, rd_arm_q;
  logic [DATA_W-1:0]   in_buf_q  [N_WORDS];
  logic [DATA_W-1:0]   out_buf_q [N_WORDS];

  logic                wr_edge, rd_edge, last_read;
  logic [DATA_W-1:0]   src_word, proc_word;

  function automatic logic [DATA_W-1:0] rev_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] rev_idx(input logic [IDX_W-1:0] x);
    logic [IDX_W-1:0] r;
    for (int i = 0; i < IDX_W; i++) r[i] = x[IDX_W-1-i];
    return r;
  endfunction

  // The arm flags keep a strobe that is already high when reset lifts from counting as an edge.
  assign wr_edge   = write_i & ~wr_prev_q & wr_arm_q;
  assign rd_edge   = read_i  & ~rd_prev_q & rd_arm_q;
  assign last_read = rd_edge && (rd_ptr_q == LAST);

  assign src_word  = in_buf_q[mode_q[1] ? rev_idx(k_q) : k_q];
  assign proc_word = mode_q[0] ? rev_word(src_word) : src_word;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= LOAD;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (start_flag_i)   state_d = PROC;
      PROC:    if (k_q == LAST)    state_d = DONE;
      DONE:    if (last_read)      state_d = LOAD;
      default:                     state_d = LOAD;
    endcase
  end

  always_comb begin
    busy_o      = (state_q == PROC);
    done_flag_o = (state_q == DONE);
    dout_o      = (state_q == DONE) ? out_buf_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      k_q       <= '0;
      mode_q    <= '0;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
      wr_arm_q  <= 1'b0;
      rd_arm_q  <= 1'b0;
      for (int i = 0; i < N_WORDS; i++) begin
        in_buf_q[i]  <= '0;
        out_buf_q[i] <= '0;
      end
    end else begin
      wr_prev_q <= write_i;
      rd_prev_q <= read_i;
      wr_arm_q  <= wr_arm_q | ~write_i;
      rd_arm_q  <= rd_arm_q | ~read_i;
      case (state_q)
        LOAD: begin
          if (wr_edge && !wr_ptr_q[IDX_W]) begin
            in_buf_q[wr_ptr_q[IDX_W-1:0]] <= din_i;
            wr_ptr_q <= wr_ptr_q + (IDX_W+1)'(1);
          end
          if (start_flag_i) begin
            mode_q <= mode_i;
            k_q    <= '0;
          end
        end
        PROC: begin
          out_buf_q[k_q] <= proc_word;
          k_q            <= k_q + IDX_W'(1);
        end
        DONE: begin
          if (last_read) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < N_WORDS; i++) in_buf_q[i] <= '0;
          end else if (rd_edge) begin
            rd_ptr_q <= rd_ptr_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
